// File: rtl/l0_ctrl_pkg.sv
// Shared types and defaults for the L0 activation buffer sequencer.
package l0_ctrl_pkg;

    // Run-level sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default geometry of the L0 buffer and the activation SRAM.
    localparam int DEF_ROW    = 8;
    localparam int DEF_BW     = 4;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_LEN_W  = 10;

    // Activation SRAM read latency in cycles (address to data valid).
    localparam int SRAM_LAT = 1;

endpackage : l0_ctrl_pkg

// File: rtl/l0_seq_ctrl.sv
// L0 activation buffer sequencer: streams num_vec vectors from the activation
// SRAM into the row FIFOs and drains them into the MAC array, one l0_rd per
// vector. Issue is throttled by L0 occupancy and l0_full, drain by array_rdy.
// After the last read the TAIL state waits for the stagger to empty row row-1.
module l0_seq_ctrl
    import l0_ctrl_pkg::*;
#(
    parameter int row    = DEF_ROW,
    parameter int depth  = DEF_DEPTH,
    parameter int addr_w = DEF_ADDR_W,
    parameter int len_w  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] base_addr,
    input  logic [len_w-1:0]  num_vec,
    input  logic              array_rdy,
    input  logic              l0_full,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [addr_w-1:0] sram_addr,
    output logic              l0_wr,
    output logic              l0_rd,
    output logic              busy,
    output logic              done
);

    // Counters carry one extra bit so num_vec at its maximum never wraps.
    localparam int cnt_w  = len_w + 1;
    localparam int tail_w = $clog2(row) + 1;

    // Occupancy ceiling: row slots stay free for the stagger and the
    // SRAM read that is still in flight when l0_full rises.
    localparam logic [cnt_w-1:0]  occ_lim  = cnt_w'(depth - row);
    localparam logic [cnt_w-1:0]  cnt_one  = cnt_w'(1);
    localparam logic [tail_w-1:0] tail_one = tail_w'(1);
    localparam logic [tail_w-1:0] tail_end = tail_w'(row - 1);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [addr_w-1:0]   r_base_addr,  w_base_addr;
    logic [cnt_w-1:0]    r_num_vec,    w_num_vec;
    logic [cnt_w-1:0]    r_iss_cnt,    w_iss_cnt;
    logic [cnt_w-1:0]    r_wr_cnt,     w_wr_cnt;
    logic [cnt_w-1:0]    r_rd_cnt,     w_rd_cnt;
    logic [tail_w-1:0]   r_tail_cnt,   w_tail_cnt;

    logic                r_sram_cen,   w_sram_cen;
    logic [addr_w-1:0]   r_sram_addr,  w_sram_addr;
    logic                r_l0_wr,      w_l0_wr;
    logic                r_l0_rd,      w_l0_rd;
    logic                r_busy,       w_busy;
    logic                r_done,       w_done;

    logic [cnt_w-1:0]    w_occ;
    logic                w_can_issue;
    logic                w_can_drain;

    // Issue / drain qualifiers from the registered counters.
    always_comb begin
        w_occ       = r_iss_cnt - r_rd_cnt;
        w_can_issue = (r_iss_cnt < r_num_vec) && (w_occ < occ_lim) && !l0_full;
        w_can_drain = (r_rd_cnt < r_num_vec) && (r_wr_cnt > r_rd_cnt) && array_rdy;
    end

    // Next state, next counters and next (registered) output values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        w_state_nxt = r_state;
        w_base_addr = r_base_addr;
        w_num_vec   = r_num_vec;
        w_iss_cnt   = r_iss_cnt;
        w_wr_cnt    = r_wr_cnt;
        w_rd_cnt    = r_rd_cnt;
        w_tail_cnt  = r_tail_cnt;
        w_sram_cen  = 1'b1;
        w_sram_addr = r_sram_addr;
        w_l0_wr     = ~r_sram_cen;
        w_l0_rd     = 1'b0;
        w_busy      = r_busy;
        w_done      = 1'b0;

        // SRAM data arrives one cycle after each enabled read.
        if (w_l0_wr) begin
            w_wr_cnt = r_wr_cnt + cnt_one;
        end

        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_base_addr = base_addr;
                    w_num_vec   = cnt_w'(num_vec);
                    w_iss_cnt   = '0;
                    w_wr_cnt    = '0;
                    w_rd_cnt    = '0;
                    w_tail_cnt  = '0;
                    w_busy      = 1'b1;
                    if (num_vec == '0) begin
                        w_state_nxt = DONE;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                        // First read goes out in the first busy cycle.
                        if (!l0_full) begin
                            w_sram_cen  = 1'b0;
                            w_sram_addr = base_addr;
                            w_iss_cnt   = cnt_one;
                        end
                    end
                end
            end

            RUN: begin
                if (w_can_issue) begin
                    w_sram_cen  = 1'b0;
                    w_sram_addr = r_base_addr + addr_w'(r_iss_cnt);
                    w_iss_cnt   = r_iss_cnt + cnt_one;
                end
                if (w_can_drain) begin
                    w_l0_rd  = 1'b1;
                    w_rd_cnt = r_rd_cnt + cnt_one;
                end
                // The cycle after the last read is already one stagger step.
                if (r_rd_cnt == r_num_vec) begin
                    w_state_nxt = TAIL;
                    w_tail_cnt  = tail_one;
                end
            end

            TAIL: begin
                if (r_tail_cnt >= tail_end) begin
                    w_state_nxt = DONE;
                    w_done      = 1'b1;
                end else begin
                    w_tail_cnt = r_tail_cnt + tail_one;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
                w_busy      = 1'b0;
            end

            default: begin
                w_state_nxt = IDLE;
                w_busy      = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, captured run parameters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base_addr <= '0;
            r_num_vec   <= '0;
            r_iss_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_tail_cnt  <= '0;
            r_sram_cen  <= 1'b1;
            r_sram_addr <= '0;
            r_l0_wr     <= 1'b0;
            r_l0_rd     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_base_addr <= w_base_addr;
            r_num_vec   <= w_num_vec;
            r_iss_cnt   <= w_iss_cnt;
            r_wr_cnt    <= w_wr_cnt;
            r_rd_cnt    <= w_rd_cnt;
            r_tail_cnt  <= w_tail_cnt;
            r_sram_cen  <= w_sram_cen;
            r_sram_addr <= w_sram_addr;
            r_l0_wr     <= w_l0_wr;
            r_l0_rd     <= w_l0_rd;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign sram_cen  = r_sram_cen;
    assign sram_wen  = 1'b1;
    assign sram_addr = r_sram_addr;
    assign l0_wr     = r_l0_wr;
    assign l0_rd     = r_l0_rd;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule : l0_seq_ctrl

// File: tb/tb_l0_seq_ctrl.sv
// Self-checking bench for l0_seq_ctrl: a table of runs applied in a loop,
// an address scoreboard filled at start and drained on each SRAM read, plus
// hand-written reset sequences.
module tb_l0_seq_ctrl;
    import l0_ctrl_pkg::*;

    localparam int ROW    = 8;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 11;
    localparam int LEN_W  = 10;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  num;
        int                rdy_mode;   // 0 always, 1 toggling, 2 low until cycle 80
        bit                full_pulse; // l0_full high during cycles 2..6
        bit                restart;    // extra start pulse during the run
        int                exp_done;   // fixed done cycle, -1 when derived only
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_vec;
    logic              array_rdy;
    logic              l0_full;
    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic              l0_wr;
    logic              l0_rd;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] addr_q[$];
    vec_t              vecs[8];

    always #5 clk = ~clk;

    l0_seq_ctrl #(
        .row    (ROW),
        .depth  (DEPTH),
        .addr_w (ADDR_W),
        .len_w  (LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_vec   (num_vec),
        .array_rdy (array_rdy),
        .l0_full   (l0_full),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .l0_wr     (l0_wr),
        .l0_rd     (l0_rd),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 1;
            default: return cyc >= 80;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cen"},  32'(sram_cen),  32'd1);
        check({tag, "_wen"},  32'(sram_wen),  32'd1);
        check({tag, "_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_wr"},   32'(l0_wr),     32'd0);
        check({tag, "_rd"},   32'(l0_rd),     32'd0);
        check({tag, "_busy"}, 32'(busy),      32'd0);
        check({tag, "_done"}, 32'(done),      32'd0);
    endtask

    // One complete run: start in cycle 0, observe from cycle 1 until done.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc, cen_cnt, wr_cnt, rd_cnt, done_cyc, last_rd, first_cen, first_wr;
        int order_err, busy_err, idle_err;
        bit finished, prev_cen_low, prev_rdy, prev_full;
        logic [ADDR_W-1:0] exp_addr;
        string tag;
        tag = $sformatf("v%0d", idx);

        addr_q.delete();
        for (int i = 0; i < int'(v.num); i++) begin
            addr_q.push_back(v.base + ADDR_W'(i));
        end

        cyc = 0; cen_cnt = 0; wr_cnt = 0; rd_cnt = 0; done_cyc = -1; last_rd = -1;
        first_cen = -1; first_wr = -1; order_err = 0; busy_err = 0; idle_err = 0;
        finished = 1'b0; prev_cen_low = 1'b0;

        base_addr = v.base;
        num_vec   = v.num;
        start     = 1'b1;
        array_rdy = rdy_for(v.rdy_mode, 0);
        l0_full   = 1'b0;
        prev_rdy  = array_rdy;
        prev_full = l0_full;

        while (!finished && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!sram_cen) begin
                cen_cnt++;
                if (first_cen < 0) first_cen = cyc;
                if (prev_full) check({tag, "_issue_while_full"}, 32'(cyc), 32'd0);
                if (addr_q.size() == 0) begin
                    check({tag, "_extra_issue"}, 32'(cyc), 32'd0);
                end else begin
                    exp_addr = addr_q.pop_front();
                    check({tag, "_addr"}, 32'(sram_addr), 32'(exp_addr));
                end
            end
            if (l0_wr !== prev_cen_low) order_err++;
            if (l0_rd) begin
                if (!prev_rdy) order_err++;
                if (rd_cnt >= wr_cnt) order_err++;
                rd_cnt++;
                last_rd = cyc;
            end
            if (l0_wr) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
            end
            if (cen_cnt - rd_cnt > DEPTH - ROW) order_err++;
            if (busy !== 1'b1) busy_err++;
            if (done) begin
                done_cyc = cyc;
                finished = 1'b1;
            end
            if (v.rdy_mode == 2 && cyc == 80) begin
                check({tag, "_occ_stall"}, 32'(cen_cnt), 32'(DEPTH - ROW));
                check({tag, "_no_rd_stalled"}, 32'(rd_cnt), 32'd0);
            end
            prev_cen_low = !sram_cen;

            if (v.restart && cyc == 5) begin
                start     = 1'b1;
                base_addr = 11'h7FF;
                num_vec   = 10'd3;
            end else begin
                start = 1'b0;
            end
            array_rdy = rdy_for(v.rdy_mode, cyc);
            l0_full   = v.full_pulse && cyc >= 2 && cyc <= 6;
            prev_rdy  = array_rdy;
            prev_full = l0_full;
        end

        if (!finished) check({tag, "_timeout"}, 32'(cyc), 32'd0);
        check({tag, "_issues"}, 32'(cen_cnt), 32'(v.num));
        check({tag, "_writes"}, 32'(wr_cnt), 32'(v.num));
        check({tag, "_reads"},  32'(rd_cnt), 32'(v.num));
        check({tag, "_sb_left"}, 32'(addr_q.size()), 32'd0);
        check({tag, "_order"}, 32'(order_err), 32'd0);
        check({tag, "_busy"},  32'(busy_err), 32'd0);
        if (v.num == '0) begin
            check({tag, "_done_cyc"}, 32'(done_cyc), 32'd1);
        end else begin
            check({tag, "_done_lag"}, 32'(done_cyc), 32'(last_rd + ROW));
            check({tag, "_first_cen"}, 32'(first_cen), 32'd1);
            check({tag, "_first_wr"}, 32'(first_wr), 32'(1 + SRAM_LAT));
        end
        if (v.exp_done >= 0) check({tag, "_done_exp"}, 32'(done_cyc), 32'(v.exp_done));

        // Back in IDLE: no busy, no second done, no further reads.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (busy || done || !sram_cen || l0_wr || l0_rd) idle_err++;
        end
        check({tag, "_idle_after"}, 32'(idle_err), 32'd0);
    endtask

    initial begin
        int rds, bad;

        vecs[0] = '{11'h010, 10'd4,   0, 1'b0, 1'b0, 14};
        vecs[1] = '{11'h100, 10'd0,   0, 1'b0, 1'b0, 1};
        vecs[2] = '{11'h020, 10'd100, 2, 1'b0, 1'b0, -1};
        vecs[3] = '{11'h030, 10'd10,  1, 1'b0, 1'b0, -1};
        vecs[4] = '{11'h040, 10'd6,   0, 1'b0, 1'b1, 16};
        vecs[5] = '{11'h7FE, 10'd5,   0, 1'b0, 1'b0, 15};
        vecs[6] = '{11'h200, 10'd12,  0, 1'b1, 1'b0, -1};
        vecs[7] = '{11'h300, 10'd1,   0, 1'b0, 1'b0, 11};

        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_vec   = '0;
        array_rdy = 1'b0;
        l0_full   = 1'b0;

        #12;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Abort a 20-vector run after its fifth read.
        @(posedge clk);
        #1;
        base_addr = 11'h050;
        num_vec   = 10'd20;
        array_rdy = 1'b1;
        start     = 1'b1;
        rds       = 0;
        for (int i = 0; i < 100 && rds < 5; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (l0_rd) rds++;
        end
        check("abort_reads_seen", 32'(rds), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) bad++;
        end
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done || busy || !sram_cen || l0_wr || l0_rd) bad++;
        end
        check("abort_quiet", 32'(bad), 32'd0);

        foreach (vecs[i]) begin
            run_vec(vecs[i], i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_l0_seq_ctrl
